// File: rtl/hub75_bcm_driver.sv
// HUB75 LED-matrix scan driver with binary-code-modulation colour depth.
// Define HUB75_DIM_EN to add a 2-bit dim input that shortens every display slot.
module hub75_bcm_driver #(
  parameter int COLS     = 32,
  parameter int ADDR_W   = 3,
  parameter int BPC      = 4,
  parameter int BASE_CYC = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
`ifdef HUB75_DIM_EN
  input  logic [1:0]              dim,
`endif
  output logic [ADDR_W-1:0]       pix_row,
  output logic [$clog2(COLS)-1:0] pix_col,
  input  logic [3*BPC-1:0]        pix_top,
  input  logic [3*BPC-1:0]        pix_bot,
  output logic                    r1,
  output logic                    g1,
  output logic                    b1,
  output logic                    r2,
  output logic                    g2,
  output logic                    b2,
  output logic [ADDR_W-1:0]       abc,
  output logic                    oclk,
  output logic                    lat,
  output logic                    oe_n,
  output logic                    frame_done
);
  localparam int CW = $clog2(COLS);
  localparam int PW = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int DW = $clog2(BASE_CYC << (BPC - 1)) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    LATCH   = 2'd2,
    DISPLAY = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] row_r;
  logic [PW-1:0]     plane_r;
  logic [CW-1:0]     col_r;
  logic [1:0]        phase_r;
  logic [DW-1:0]     disp_cnt_r, slot_len_s, disp_len_s;
  logic              col_last_s, plane_last_s, disp_last_s, frame_end_s;
  logic              oclk_d_s, lat_d_s, oe_n_d_s, frame_done_d_s;
  logic [ADDR_W-1:0] abc_d_s;
  logic [BPC-1:0]    top_r_s, top_g_s, top_b_s, bot_r_s, bot_g_s, bot_b_s;

  assign top_r_s = pix_top[3*BPC-1:2*BPC];
  assign top_g_s = pix_top[2*BPC-1:BPC];
  assign top_b_s = pix_top[BPC-1:0];
  assign bot_r_s = pix_bot[3*BPC-1:2*BPC];
  assign bot_g_s = pix_bot[2*BPC-1:BPC];
  assign bot_b_s = pix_bot[BPC-1:0];

  assign col_last_s   = (col_r == CW'(COLS - 1));
  assign plane_last_s = (plane_r == PW'(BPC - 1));
  assign disp_last_s  = (disp_cnt_r == {DW{1'b0}});
  assign frame_end_s  = plane_last_s && (&row_r);
  assign slot_len_s   = DW'(BASE_CYC) << plane_r;

`ifdef HUB75_DIM_EN
  logic [DW-1:0] dim_len_s;
  assign dim_len_s  = slot_len_s >> dim;
  assign disp_len_s = (dim_len_s == {DW{1'b0}}) ? DW'(1'b1) : dim_len_s;
`else
  assign disp_len_s = slot_len_s;
`endif

  assign pix_row = row_r;
  assign pix_col = col_r;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic; en only matters in IDLE and at the frame end
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (en) state_nxt_s = SHIFT;
        else    state_nxt_s = IDLE;
      end
      SHIFT: begin
        if ((phase_r == 2'd2) && col_last_s) state_nxt_s = LATCH;
        else                                 state_nxt_s = SHIFT;
      end
      LATCH: state_nxt_s = DISPLAY;
      DISPLAY: begin
        if (disp_last_s && frame_end_s && !en) state_nxt_s = IDLE;
        else if (disp_last_s)                  state_nxt_s = SHIFT;
        else                                   state_nxt_s = DISPLAY;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Panel control values to be registered at the end of this cycle
  always_comb begin
    oclk_d_s       = 1'b0;
    lat_d_s        = 1'b0;
    oe_n_d_s       = 1'b1;
    abc_d_s        = abc;
    frame_done_d_s = 1'b0;
    case (state_r)
      SHIFT:   oclk_d_s = (phase_r == 2'd2);
      LATCH: begin
        lat_d_s = 1'b1;
        abc_d_s = row_r;
      end
      DISPLAY: begin
        oe_n_d_s       = 1'b0;
        frame_done_d_s = disp_last_s && frame_end_s;
      end
      default: oe_n_d_s = 1'b1;
    endcase
  end

  // Panel control output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      oclk       <= 1'b0;
      lat        <= 1'b0;
      oe_n       <= 1'b1;
      abc        <= {ADDR_W{1'b0}};
      frame_done <= 1'b0;
    end else begin
      oclk       <= oclk_d_s;
      lat        <= lat_d_s;
      oe_n       <= oe_n_d_s;
      abc        <= abc_d_s;
      frame_done <= frame_done_d_s;
    end
  end

  // Scan counters: phase within a column, column, plane, row, display slot
  always_ff @(posedge clk) begin
    if (reset) begin
      row_r      <= {ADDR_W{1'b0}};
      plane_r    <= {PW{1'b0}};
      col_r      <= {CW{1'b0}};
      phase_r    <= 2'd0;
      disp_cnt_r <= {DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          row_r   <= {ADDR_W{1'b0}};
          plane_r <= {PW{1'b0}};
          col_r   <= {CW{1'b0}};
          phase_r <= 2'd0;
        end
        SHIFT: begin
          if (phase_r == 2'd2) begin
            phase_r <= 2'd0;
            if (!col_last_s) col_r <= col_r + CW'(1'b1);
          end else begin
            phase_r <= phase_r + 2'd1;
          end
        end
        LATCH: disp_cnt_r <= disp_len_s - DW'(1'b1);
        DISPLAY: begin
          if (disp_last_s) begin
            col_r <= {CW{1'b0}};
            if (plane_last_s) begin
              plane_r <= {PW{1'b0}};
              row_r   <= row_r + ADDR_W'(1'b1);
            end else begin
              plane_r <= plane_r + PW'(1'b1);
            end
          end else begin
            disp_cnt_r <= disp_cnt_r - DW'(1'b1);
          end
        end
        default: phase_r <= 2'd0;
      endcase
    end
  end

  // Colour bits: framebuffer data is valid in the second cycle of each column
  always_ff @(posedge clk) begin
    if (reset) begin
      {r1, g1, b1, r2, g2, b2} <= 6'b000000;
    end else if ((state_r == SHIFT) && (phase_r == 2'd1)) begin
      r1 <= top_r_s[plane_r];
      g1 <= top_g_s[plane_r];
      b1 <= top_b_s[plane_r];
      r2 <= bot_r_s[plane_r];
      g2 <= bot_g_s[plane_r];
      b2 <= bot_b_s[plane_r];
    end
  end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Scoreboard bench for hub75_bcm_driver (COLS=4, ADDR_W=1, BPC=2, BASE_CYC=2).
// Expectations are queued by the stimulus; a negedge monitor pops them on panel events.
module tb_hub75_bcm_driver;
  logic       clk = 1'b0;
  logic       reset, en;
  logic [1:0] dim;
  logic       pix_row;
  logic [1:0] pix_col;
  logic [5:0] pix_top, pix_bot;
  logic       r1, g1, b1, r2, g2, b2, abc, oclk, lat, oe_n, frame_done;

  always #5 clk = ~clk;

  hub75_bcm_driver #(.COLS(4), .ADDR_W(1), .BPC(2), .BASE_CYC(2)) dut (
`ifdef HUB75_DIM_EN
    .dim(dim),
`endif
    .clk(clk), .reset(reset), .en(en),
    .pix_row(pix_row), .pix_col(pix_col), .pix_top(pix_top), .pix_bot(pix_bot),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .abc(abc), .oclk(oclk), .lat(lat), .oe_n(oe_n), .frame_done(frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // {r1,g1,b1,r2,g2,b2} per data set and plane, worked out by hand:
  // set 0: top 10_01_11, bot 01_10_00;  set 1: top 01_10_00, bot 11_00_10
  logic [5:0] exp_col [2][2] = '{'{6'b011_100, 6'b101_010}, '{6'b100_100, 6'b010_101}};

  logic [5:0] col_q[$];
  int         abc_q[$];
  int         oe_q[$];
  int         fr_q[$];

  bit mon_en = 1'b0;
  int frames_seen = 0, lat_seen = 0, rises_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_plane(input logic [5:0] c, input int row, input int oe_len);
    repeat (4) col_q.push_back(c);
    abc_q.push_back(row);
    if (oe_len > 0) oe_q.push_back(oe_len);
  endtask

  task automatic push_frame(input int ds, input int len0, input int len1, input int period);
    for (int r = 0; r < 2; r++) begin
      push_plane(exp_col[ds][0], r, len0);
      push_plane(exp_col[ds][1], r, len1);
    end
    fr_q.push_back(period);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_wait", int'(frames_seen >= target), 1);
  endtask

  task automatic wait_lats(input int target, input int budget);
    int n = 0;
    while (lat_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("lat_wait", int'(lat_seen >= target), 1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((col_q.size() + abc_q.size() + oe_q.size() + fr_q.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", col_q.size() + abc_q.size() + oe_q.size() + fr_q.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    int base;
    base = rises_total;
    repeat (30) @(negedge clk);
    check({tag, "_oclk_edges"}, rises_total - base, 0);
    check({tag, "_oe_n"}, int'(oe_n), 1);
  endtask

  // Monitor: pops and compares on oclk rise, lat rise, end of oe_n-low run, frame_done
  initial begin
    logic oclk_q = 1'b0, lat_q = 1'b0;
    int   run = 0, rises_frame = 0, cyc_fd = 0, period;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cyc_fd++;
        if (oclk && !oclk_q) begin
          rises_total++;
          rises_frame++;
          if (col_q.size() == 0) check("unexpected_oclk", 1, 0);
          else check("colour_at_oclk", int'({r1, g1, b1, r2, g2, b2}), int'(col_q.pop_front()));
        end
        if (lat && !lat_q) begin
          lat_seen++;
          check("oe_n_during_lat", int'(oe_n), 1);
          if (abc_q.size() == 0) check("unexpected_lat", 1, 0);
          else begin
            int r;
            r = abc_q.pop_front();
            check("abc_at_lat", int'(abc), r);
            check("pix_row_at_lat", int'(pix_row), r);
          end
        end
        if (!oe_n) run++;
        else if (run > 0) begin
          if (oe_q.size() == 0) check("unexpected_oe_run", 1, 0);
          else check("oe_low_cycles", run, oe_q.pop_front());
          run = 0;
        end
        if (frame_done) begin
          frames_seen++;
          if (fr_q.size() == 0) check("unexpected_frame_done", 1, 0);
          else begin
            period = fr_q.pop_front();
            check("oclk_per_frame", rises_frame, 16);
            if (period != 0) check("frame_period", cyc_fd, period);
          end
          cyc_fd = 0;
          rises_frame = 0;
        end
      end else begin
        run = 0;
        rises_frame = 0;
        cyc_fd = 0;
      end
      oclk_q = oclk;
      lat_q  = lat;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fs;
    reset = 1'b1; en = 1'b0; dim = 2'd0;
    pix_top = 6'b10_01_11; pix_bot = 6'b01_10_00;
    repeat (3) @(negedge clk);
    check("rst_oe_n", int'(oe_n), 1);
    check("rst_lat", int'(lat), 0);
    check("rst_oclk", int'(oclk), 0);
    check("rst_abc", int'(abc), 0);
    check("rst_colour", int'({r1, g1, b1, r2, g2, b2}), 0);
    check("rst_pix_row", int'(pix_row), 0);
    check("rst_pix_col", int'(pix_col), 0);
    check("rst_frame_done", int'(frame_done), 0);

    // Released with en low: stays idle
    reset = 1'b0; mon_en = 1'b1;
    check_idle("idle_no_en");

    // Three frames with en held, en dropped 20 cycles into the third
    push_frame(0, 2, 4, 0);
    push_frame(0, 2, 4, 64);
    push_frame(0, 2, 4, 64);
    en = 1'b1;
    wait_frames(2, 300);
    repeat (20) @(negedge clk);
    en = 1'b0;
    wait_drain(300);
    check_idle("idle_after_stop");

    // New data, then reset during the first display slot of row 1
    pix_top = 6'b01_10_00; pix_bot = 6'b11_00_10;
    fs = lat_seen;
    push_plane(exp_col[1][0], 0, 2);
    push_plane(exp_col[1][1], 0, 4);
    push_plane(exp_col[1][0], 1, 0);
    en = 1'b1;
    wait_lats(fs + 3, 200);
    @(negedge clk);
    check("pre_reset_oe_n", int'(oe_n), 0);
    check("pre_reset_pending", col_q.size() + abc_q.size() + oe_q.size(), 0);
    mon_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_oe_n", int'(oe_n), 1);
    check("mid_rst_lat", int'(lat), 0);
    check("mid_rst_abc", int'(abc), 0);
    check("mid_rst_colour", int'({r1, g1, b1, r2, g2, b2}), 0);
    check("mid_rst_pix_row", int'(pix_row), 0);
    col_q.delete(); abc_q.delete(); oe_q.delete(); fr_q.delete();

    // Restart from row 0 plane 0 with en still high; stop after one frame
    push_frame(1, 2, 4, 0);
    reset = 1'b0; mon_en = 1'b1;
    repeat (20) @(negedge clk);
    en = 1'b0;
    wait_drain(300);
    check_idle("idle_after_restart");

`ifdef HUB75_DIM_EN
    // dim=1 halves each slot; dim=3 clamps both planes to one cycle
    dim = 2'd1;
    fs = frames_seen;
    push_frame(1, 1, 2, 0);
    en = 1'b1;
    wait_frames(fs + 1, 200);
    dim = 2'd3;
    push_frame(1, 1, 1, 56);
    repeat (20) @(negedge clk);
    en = 1'b0;
    wait_drain(300);
    check_idle("idle_after_dim");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
